// File: rtl/mod_counter_n.sv
// mod_counter_n: modulo-M up/down counter with 74LS161-style clear/load/enables,
// cascade carry-out, registered wrap pulse and sticky overflow flag.
module mod_counter_n #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en_p,
    input  logic             en_t,
    input  logic             up,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co,
    output logic             wrap,
    output logic             ovf
);
    // One extra bit so MODULUS = 2^WIDTH is representable.
    localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_illegal;
    logic             w_count;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_ld_val;
    logic [WIDTH-1:0] w_q_next;

    assign w_at_max   = (r_q == LP_MAX);
    assign w_at_zero  = (r_q == '0);
    assign w_illegal  = ({1'b0, r_q} >= LP_MOD);
    assign w_count    = en_p & en_t & ~clr & ~ld;
    // An escape from an illegal state lands on 0 but is not a wrap.
    assign w_wrap_evt = w_count & ~w_illegal & (up ? w_at_max : w_at_zero);
    assign w_ld_val   = ({1'b0, d} < LP_MOD) ? d : LP_MAX;

    always_comb begin
        w_q_next = r_q;
        if (clr) begin
            w_q_next = '0;
        end else if (ld) begin
            w_q_next = w_ld_val;
        end else if (en_p & en_t) begin
            if (w_illegal)
                w_q_next = '0;
            else if (up)
                w_q_next = w_at_max ? '0 : r_q + 1'b1;
            else
                w_q_next = w_at_zero ? LP_MAX : r_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_evt;
            if (w_wrap_evt)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tc   = up ? w_at_max : w_at_zero;
    assign co   = tc & en_t;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_mod_counter_n.sv
// Bench for mod_counter_n: directed vector table, randomized run against a
// modular-arithmetic reference model, a two-stage decade cascade and an 8-bit case.
module tb_mod_counter_n;
    localparam int M = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Main DUT (WIDTH=4, M=10)
    logic       rst, clr, ld, en_p, en_t, up, ovf_clr;
    logic [3:0] d, q;
    logic       tc, co, wrap, ovf;

    mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en_p(en_p), .en_t(en_t),
        .up(up), .ovf_clr(ovf_clr), .q(q), .tc(tc), .co(co), .wrap(wrap), .ovf(ovf)
    );

    // Decade cascade
    logic       c_rst, c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_wrap, lo_ovf, hi_tc, hi_co, hi_wrap, hi_ovf;

    mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst(c_rst), .clr(1'b0), .ld(1'b0), .d(4'd0), .en_p(c_en), .en_t(1'b1),
        .up(1'b1), .ovf_clr(1'b0), .q(lo_q), .tc(lo_tc), .co(lo_co), .wrap(lo_wrap), .ovf(lo_ovf)
    );
    mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst(c_rst), .clr(1'b0), .ld(1'b0), .d(4'd0), .en_p(c_en), .en_t(lo_co),
        .up(1'b1), .ovf_clr(1'b0), .q(hi_q), .tc(hi_tc), .co(hi_co), .wrap(hi_wrap), .ovf(hi_ovf)
    );

    // Full-range 8-bit instance
    logic       w_rst, w_ld, w_en;
    logic [7:0] w_d, w_q;
    logic       w_tc, w_co, w_wrap, w_ovf;

    mod_counter_n #(.WIDTH(8), .MODULUS(256)) u_w8 (
        .clk(clk), .rst(w_rst), .clr(1'b0), .ld(w_ld), .d(w_d), .en_p(w_en), .en_t(w_en),
        .up(1'b1), .ovf_clr(1'b0), .q(w_q), .tc(w_tc), .co(w_co), .wrap(w_wrap), .ovf(w_ovf)
    );

    // Reference model state for u_dut
    int mq = 0, mw = 0, mo = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance the model from the current inputs, then clock the DUTs.
    task automatic tick();
        int ev;
        ev = 0;
        if (rst) begin
            mq = 0; mw = 0; mo = 0;
        end else begin
            if (clr)
                mq = 0;
            else if (ld)
                mq = (int'(d) < M) ? int'(d) : M - 1;
            else if (en_p && en_t) begin
                if (mq >= M)
                    mq = 0;
                else if (up) begin
                    ev = (mq == M - 1);
                    mq = (mq + 1) % M;
                end else begin
                    ev = (mq == 0);
                    mq = (mq + M - 1) % M;
                end
            end
            mw = ev;
            if (ev) mo = 1;
            else if (ovf_clr) mo = 0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, clr, ld; logic [3:0] d; logic ep, et, up, oc;
        logic [3:0] q; logic tc, co, wr, ov;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(logic r, logic c, logic l, logic [3:0] dd, logic ep, logic et,
                               logic u, logic oc, logic [3:0] eq, logic etc, logic eco,
                               logic ew, logic eo);
        vec_t x;
        x.rst = r; x.clr = c; x.ld = l; x.d = dd; x.ep = ep; x.et = et; x.up = u; x.oc = oc;
        x.q = eq; x.tc = etc; x.co = eco; x.wr = ew; x.ov = eo;
        return x;
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; ld = 1'b0; d = '0; en_p = 1'b0; en_t = 1'b0; up = 1'b1; ovf_clr = 1'b0;
        c_rst = 1'b1; c_en = 1'b0;
        w_rst = 1'b1; w_ld = 1'b0; w_en = 1'b0; w_d = '0;

        //          rst clr ld d  ep et up oc   q  tc co wr ov
        vt.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        for (int i = 1; i <= 9; i++)
            vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 0, 4'(i), i == 9, i == 9, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 1, 1));   // 9 -> 0 wraps
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 0,  1, 0, 0, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 0,  2, 0, 0, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1));   // down from 2
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 1, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  9, 0, 0, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  8, 0, 0, 0, 1));
        vt.push_back(v(0, 0, 1, 7, 0, 0, 1, 0,  7, 0, 0, 0, 1));   // load, enables off
        vt.push_back(v(0, 0, 1, 12, 0, 0, 1, 0, 9, 1, 0, 0, 1));   // clamp
        vt.push_back(v(0, 0, 0, 0, 1, 0, 1, 0,  9, 1, 0, 0, 1));   // en_t=0 holds
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0,  9, 1, 1, 0, 1));   // en_p=0 holds, co=1
        vt.push_back(v(0, 0, 1, 3, 1, 1, 1, 0,  3, 0, 0, 0, 1));   // load at 9: no wrap
        vt.push_back(v(0, 1, 1, 7, 1, 1, 1, 0,  0, 0, 0, 0, 1));   // clr beats ld
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0));   // ovf_clr alone
        vt.push_back(v(0, 0, 1, 9, 0, 0, 1, 0,  9, 1, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 1, 1));   // set beats ovf_clr
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 0,  1, 0, 0, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 9, 0, 0, 1, 0,  9, 1, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 1, 1));
        vt.push_back(v(0, 0, 1, 9, 0, 0, 1, 0,  9, 1, 0, 0, 1));
        vt.push_back(v(1, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0));   // rst at 9 while counting
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 5, 0, 0, 1, 0,  5, 0, 0, 0, 0));
        vt.push_back(v(0, 1, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0));   // clr while counting
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  9, 0, 0, 1, 1));   // 0 -> 9 down wrap

        foreach (vt[i]) begin
            rst = vt[i].rst; clr = vt[i].clr; ld = vt[i].ld; d = vt[i].d;
            en_p = vt[i].ep; en_t = vt[i].et; up = vt[i].up; ovf_clr = vt[i].oc;
            tick();
            chk($sformatf("vec%0d q", i),    q,    vt[i].q);
            chk($sformatf("vec%0d tc", i),   tc,   vt[i].tc);
            chk($sformatf("vec%0d co", i),   co,   vt[i].co);
            chk($sformatf("vec%0d wrap", i), wrap, vt[i].wr);
            chk($sformatf("vec%0d ovf", i),  ovf,  vt[i].ov);
        end

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            clr     = ($urandom_range(0, 19) == 0);
            ld      = ($urandom_range(0, 7) == 0);
            d       = 4'($urandom_range(0, 15));
            en_p    = ($urandom_range(0, 3) != 0);
            en_t    = ($urandom_range(0, 3) != 0);
            up      = 1'($urandom_range(0, 1));
            ovf_clr = ($urandom_range(0, 9) == 0);
            tick();
            chk($sformatf("rnd%0d q", i),    q,    mq);
            chk($sformatf("rnd%0d tc", i),   tc,   up ? (mq == M - 1) : (mq == 0));
            chk($sformatf("rnd%0d co", i),   co,   en_t && (up ? (mq == M - 1) : (mq == 0)));
            chk($sformatf("rnd%0d wrap", i), wrap, mw);
            chk($sformatf("rnd%0d ovf", i),  ovf,  mo);
        end
        rst = 1'b1; clr = 1'b0; ld = 1'b0; en_p = 1'b0; en_t = 1'b0; ovf_clr = 1'b0;

        // Decade cascade 00..99 -> 00
        @(posedge clk); #1;
        c_rst = 1'b0; c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            chk($sformatf("cascade k=%0d", k), int'(hi_q) * 10 + int'(lo_q), k % 100);
            if (k == 99) chk("cascade hi co at 99", hi_co, 1);
            if (k == 100) chk("cascade hi wrap at 00", hi_wrap, 1);
        end
        c_en = 1'b0;

        // 8-bit full range: 255 -> 0 wraps, reset at 255 discards it
        @(posedge clk); #1;
        w_rst = 1'b0; w_ld = 1'b1; w_d = 8'd254;
        @(posedge clk); #1;
        w_ld = 1'b0; w_en = 1'b1;
        @(posedge clk); #1;
        chk("w8 q=255", w_q, 255);
        chk("w8 tc at 255", w_tc, 1);
        @(posedge clk); #1;
        chk("w8 q wraps to 0", w_q, 0);
        chk("w8 wrap", w_wrap, 1);
        chk("w8 ovf", w_ovf, 1);
        w_en = 1'b0; w_ld = 1'b1; w_d = 8'd255;
        @(posedge clk); #1;
        w_ld = 1'b0; w_en = 1'b1; w_rst = 1'b1;
        @(posedge clk); #1;
        chk("w8 rst q", w_q, 0);
        chk("w8 rst wrap", w_wrap, 0);
        chk("w8 rst ovf", w_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_counter_n.md
Name: mod_counter_n

Overview:
- Parametrised synchronous counter; the next generation of the team's 4-bit 74LS161-style counter.
- Generalised to any WIDTH and to modulo-M counting, up or down.
- Keeps the 161 control set: clear, parallel load, P/T enables, carry-out for cascading.
- Adds a registered wrap pulse and a sticky overflow flag.
- Used as the building block for BCD/clock-divider chains in later labs.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MODULUS, 16, count modulus M. Count range is 0..M-1. Legal range 2 ≤ M ≤ 2^WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- clr, input, 1, synchronous clear, active-high.
- ld, input, 1, synchronous parallel load, active-high.
- d, input, WIDTH, parallel load data.
- en_p, input, 1, count enable P.
- en_t, input, 1, count enable T; also gates co.
- up, input, 1, count direction: 1 = up, 0 = down.
- q, output, WIDTH, counter state (registered).
- tc, output, 1, terminal count (combinational from q and up).
- co, output, 1, cascade carry/borrow out = tc & en_t (combinational).
- wrap, output, 1, registered one-cycle pulse after a counting wrap.
- ovf, output, 1, sticky overflow flag.
- ovf_clr, input, 1, synchronous clear of ovf, active-high.

Behaviour:
- All state changes on the rising edge of clk. No asynchronous paths.
- Reset (rst = 1), highest priority:
  - q = 0, wrap = 0, ovf = 0 on the next edge.
  - All other inputs are ignored that cycle.
  - Reset mid-count discards the count and any pending wrap.
- Priority for q when rst = 0: clr > ld > count > hold.
- clr = 1: q <= 0. No wrap. ovf unaffected except through ovf_clr.
- ld = 1 (clr = 0):
  - If d < M, q <= d; otherwise q <= M-1 (clamp).
  - Load never produces wrap.
  - Load works regardless of en_p/en_t.
- Count occurs when en_p & en_t = 1, with clr = 0 and ld = 0:
  - up = 1: q <= (q == M-1) ? 0 : q+1.
  - up = 0: q <= (q == 0) ? M-1 : q-1.
- Hold: when en_p = 0 or en_t = 0 (and no clr/ld), q holds.
- Illegal state (q ≥ M): reachable only when M < 2^WIDTH, via no legal path. A count from it goes to 0 in both directions, and this is not a wrap.
- tc:
  - up = 1: tc = (q == M-1).
  - up = 0: tc = (q == 0).
  - Independent of the enables.
- co = tc & en_t. It is not gated by en_p (161 semantics, so ripple cascades via en_t work).
- wrap:
  - Registered. wrap = 1 for exactly the one cycle after an edge on which a count moved q across a boundary (M-1 -> 0 up, or 0 -> M-1 down).
  - Otherwise wrap = 0.
  - Back-to-back wraps (M = 2, continuous count) give wrap high on consecutive cycles.
- ovf:
  - Set on the same edge that schedules wrap.
  - Cleared on an edge with ovf_clr = 1.
  - Simultaneous set and ovf_clr: set wins, ovf stays 1.
- Direction change takes effect on the next counting edge. tc and co follow up immediately (combinational).
- Latency:
  - Control inputs to q: 1 cycle.
  - q to tc/co: 0 cycles.
  - Wrap event to wrap/ovf visible: 1 cycle.

Test Plan:
- WIDTH=4, M=10. rst 1 cycle, then en_p = en_t = up = 1 for 12 cycles:
  - q = 0,1,…,9,0,1.
  - tc = 1 only while q = 9.
  - wrap = 1 only in the cycle with q = 0 after 9.
  - ovf goes 1 then stays 1.
- Same setup, up = 0 from q = 2 for 4 counts:
  - q = 1,0,9,8.
  - tc = 1 at q = 0.
  - wrap pulses once, on arriving at 9.
- Load tests:
  - ld = 1, d = 7: q = 7 next cycle, with en_p = 0 as well.
  - ld = 1, d = 12: q = 9 (clamp).
  - ld and clr asserted together: q = 0.
  - Load at q = 9 during count: no wrap.
- Enable gating at q = 9, up = 1:
  - en_t = 0: q holds, co = 0, tc = 1.
  - en_p = 0, en_t = 1: q holds, co = 1.
  - Cascade two instances (co -> en_t of the upper stage): the upper stage increments once per 10 lower counts; 00..99 reaches 99 then 00.
- ovf tests:
  - ovf = 1, assert ovf_clr alone: ovf = 0 next cycle.
  - Assert ovf_clr on the same edge as a 9->0 wrap: ovf = 1.
- Reset mid-operation:
  - rst at q = 9 with a count enabled: q = 0, wrap = 0, ovf = 0 next cycle, no wrap pulse.
  - Repeat with WIDTH=8, M=256: q = 255->0 produces wrap.
